// File: rtl/text_pkg.sv
// text_pkg: constants, FSM state type and tile address helper shared by the
// text buffer writer and its tile RAM.
//   COLS x ROWS tile grid (80x30 tiles of 8x16 pixels on a 640x480 raster),
//   BLANK fill code, ADDR_W tile RAM address width, control codes and the
//   writer FSM state enum.
package text_pkg;

   localparam int          COLS   = 80;
   localparam int          ROWS   = 30;
   localparam logic [7:0]  BLANK  = 8'h20;
   localparam int          ADDR_W = 12;   // 2**ADDR_W must cover COLS*ROWS

   localparam logic [7:0]  CC_CR  = 8'h0D;
   localparam logic [7:0]  CC_LF  = 8'h0A;
   localparam logic [7:0]  CC_BS  = 8'h08;
   localparam logic [7:0]  CC_FF  = 8'h0C;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CLR_ALL = 2'd1,
      CLR_ROW = 2'd2
   } state_t;

   // row*80 + col as row*64 + row*16 + col: shifts and adds only.
   function automatic logic [ADDR_W-1:0] tile_addr(input logic [4:0] row,
                                                   input logic [6:0] col);
      return ADDR_W'({row, 6'b0}) + ADDR_W'({row, 4'b0}) + ADDR_W'(col);
   endfunction

endpackage

// File: rtl/tile_ram.sv
// tile_ram: COLS*ROWS x 8 simple dual-port tile store.
//   clk, reset : clock, synchronous active-high reset (read register only)
//   we, waddr, wdata : synchronous write port
//   raddr, rd_oob    : read address and "coordinates off the grid" flag
//   rd_data          : registered read data, 1-cycle latency
// A read and write to the same address in one cycle returns the old data,
// which is the natural behaviour of the registered read below.
module tile_ram
   import text_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              rd_oob,
   output logic [7:0]        rd_data
);

   logic [7:0] mem [0:COLS*ROWS-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Off-grid coordinates never index the array; they read as BLANK.
   always_ff @(posedge clk) begin
      if (reset)       rd_data <= '0;
      else if (rd_oob) rd_data <= BLANK;
      else             rd_data <= mem[raddr];
   end

endmodule

// File: rtl/text_buffer_writer.sv
// text_buffer_writer: producer side of the character display path.
//   clk, reset              : clock, synchronous active-high reset
//   char_in, char_valid     : ASCII code stream in
//   char_ready              : code can be accepted this cycle
//   rd_col, rd_row, rd_ascii: renderer tile read port, 1-cycle latency
//   cursor_col, cursor_row  : current cursor position
//   busy                    : a clear (whole screen or one row) is running
// Handshake: a code transfers on a rising edge where char_valid && char_ready
// are both high; char_ready is high only in IDLE and does not depend on
// char_valid; the producer holds char_in stable until the transfer edge.
module text_buffer_writer
   import text_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] char_in,
   input  logic       char_valid,
   output logic       char_ready,
   input  logic [6:0] rd_col,
   input  logic [4:0] rd_row,
   output logic [7:0] rd_ascii,
   output logic [6:0] cursor_col,
   output logic [4:0] cursor_row,
   output logic       busy
);

   state_t            state, state_n;
   logic [6:0]        col, col_n;
   logic [4:0]        row, row_n, next_row;
   logic [ADDR_W-1:0] cnt, cnt_n;     // clear sweep position
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [7:0]        wdata;
   logic              rd_oob;
   logic              is_print;

   assign char_ready = (state == IDLE);
   assign busy       = ~char_ready;
   assign cursor_col = col;
   assign cursor_row = row;
   assign next_row   = (row == 5'(ROWS-1)) ? '0 : row + 5'd1;
   assign is_print   = (char_in >= 8'h20) && (char_in <= 8'h7E);
   assign rd_oob     = (rd_col >= 7'(COLS)) || (rd_row >= 5'(ROWS));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= CLR_ALL;
         cnt   <= '0;
         col   <= '0;
         row   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         col   <= col_n;
         row   <= row_n;
      end
   end

   always_comb begin
      state_n = state;
      col_n   = col;
      row_n   = row;
      cnt_n   = cnt;
      we      = 1'b0;
      waddr   = tile_addr(row, col);
      wdata   = BLANK;
      case (state)
         IDLE: begin
            if (char_valid) begin
               if (is_print) begin
                  we    = 1'b1;
                  wdata = char_in;
                  if (col < 7'(COLS-1)) begin
                     col_n = col + 7'd1;
                  end else begin
                     // Entering a new row: blank it before more text lands.
                     col_n   = '0;
                     row_n   = next_row;
                     cnt_n   = '0;
                     state_n = CLR_ROW;
                  end
               end else if (char_in == CC_CR) begin
                  col_n = '0;
               end else if (char_in == CC_LF) begin
                  col_n   = '0;
                  row_n   = next_row;
                  cnt_n   = '0;
                  state_n = CLR_ROW;
               end else if (char_in == CC_BS) begin
                  if (col != '0) begin
                     col_n = col - 7'd1;
                     we    = 1'b1;
                     waddr = tile_addr(row, col - 7'd1);
                  end
               end else if (char_in == CC_FF) begin
                  cnt_n   = '0;
                  state_n = CLR_ALL;
               end
               // any other code is consumed with no effect
            end
         end
         CLR_ALL: begin
            we    = 1'b1;
            waddr = cnt;
            if (cnt == ADDR_W'(COLS*ROWS-1)) begin
               state_n = IDLE;
               col_n   = '0;
               row_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         CLR_ROW: begin
            // row already points at the row being entered
            we    = 1'b1;
            waddr = tile_addr(row, cnt[6:0]);
            if (cnt == ADDR_W'(COLS-1)) state_n = IDLE;
            else                        cnt_n   = cnt + 1'b1;
         end
         default: begin
            state_n = CLR_ALL;
            cnt_n   = '0;
         end
      endcase
   end

   tile_ram u_tile_ram (
      .clk     (clk),
      .reset   (reset),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .raddr   (tile_addr(rd_row, rd_col)),
      .rd_oob  (rd_oob),
      .rd_data (rd_ascii)
   );

endmodule

// File: tb/tb_text_buffer_writer.sv
// tb_text_buffer_writer: randomized and directed stimulus for
// text_buffer_writer against a screen/cursor model kept as a plain array.
module tb_text_buffer_writer;
   import text_pkg::*;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] char_in;
   logic       char_valid;
   logic       char_ready;
   logic [6:0] rd_col;
   logic [4:0] rd_row;
   logic [7:0] rd_ascii;
   logic [6:0] cursor_col;
   logic [4:0] cursor_row;
   logic       busy;

   always #5 clk = ~clk;

   text_buffer_writer dut (
      .clk        (clk),
      .reset      (reset),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .rd_col     (rd_col),
      .rd_row     (rd_row),
      .rd_ascii   (rd_ascii),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .busy       (busy)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int last_acc = 0;
   int prev_acc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // Screen as a flat array of codes, cursor as two integers.
   logic [7:0] mm [0:COLS*ROWS-1];
   int mc, mr, exp_stall;

   task automatic model_clear_row(input int r);
      for (int c = 0; c < COLS; c++) mm[r*COLS + c] = BLANK;
   endtask

   task automatic model_clear_all();
      for (int i = 0; i < COLS*ROWS; i++) mm[i] = BLANK;
      mc = 0;
      mr = 0;
   endtask

   task automatic model_newline();
      mc = 0;
      mr = (mr + 1) % ROWS;
      model_clear_row(mr);
      exp_stall = COLS;
   endtask

   task automatic model_apply(input logic [7:0] c);
      exp_stall = 0;
      if (c >= 8'h20 && c <= 8'h7E) begin
         mm[mr*COLS + mc] = c;
         if (mc < COLS-1) mc++;
         else model_newline();
      end else if (c == 8'h0D) begin
         mc = 0;
      end else if (c == 8'h0A) begin
         model_newline();
      end else if (c == 8'h08) begin
         if (mc > 0) begin
            mc--;
            mm[mr*COLS + mc] = BLANK;
         end
      end else if (c == 8'h0C) begin
         model_clear_all();
         exp_stall = COLS*ROWS;
      end
   endtask

   function automatic logic [7:0] model_tile(input int r, input int c);
      if (r >= ROWS || c >= COLS) return BLANK;
      return mm[r*COLS + c];
   endfunction

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   logic       rd_req = 1'b0;
   logic       rd_req_d = 1'b0;

   always @(posedge clk) rd_req_d <= rd_req;

   // A read presented before edge k shows on rd_ascii after edge k.
   always @(negedge clk) begin
      if (rd_req_d) begin
         if (exp_q.size() == 0) begin
            chk("rd_unexpected", 1, 0);
         end else begin
            chk("rd_ascii", int'(rd_ascii), int'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks (called at negedge) ----------------
   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < 3000) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic send_code(input logic [7:0] c, input bit wait_done);
      int w, n;
      w = 0;
      char_in    = c;
      char_valid = 1'b1;
      while (!char_ready && w < 3000) begin
         w++;
         @(negedge clk);
      end
      chk("ready_before_accept", int'(char_ready), 1);
      @(posedge clk);
      model_apply(c);
      @(negedge clk);
      prev_acc   = last_acc;
      last_acc   = cyc;
      char_valid = 1'b0;
      if (wait_done) begin
         count_busy(n);
         chk("stall_cycles", n, exp_stall);
      end
   endtask

   task automatic read_tile(input int r, input int c);
      rd_row = 5'(r);
      rd_col = 7'(c);
      rd_req = 1'b1;
      exp_q.push_back(model_tile(r, c));
      @(negedge clk);
   endtask

   task automatic drain();
      rd_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic sweep_row(input int r);
      for (int c = 0; c < COLS; c++) read_tile(r, c);
      drain();
   endtask

   task automatic sweep_all();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) read_tile(r, c);
      drain();
   endtask

   task automatic check_cursor(input string tag);
      chk({tag, "_col"}, int'(cursor_col), mc);
      chk({tag, "_row"}, int'(cursor_row), mr);
   endtask

   function automatic logic [7:0] rand_code();
      int r;
      r = $urandom_range(0, 99);
      if (r < 70) return 8'($urandom_range(32, 126));
      if (r < 78) return 8'h0D;
      if (r < 86) return 8'h0A;
      if (r < 95) return 8'h08;
      if (r < 97) return 8'h0C;
      return 8'($urandom_range(128, 255));
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int n;
      reset      = 1'b1;
      char_valid = 1'b0;
      char_in    = 8'h00;
      rd_row     = '0;
      rd_col     = '0;
      repeat (3) @(negedge clk);
      chk("reset_rd_ascii", int'(rd_ascii), 0);
      chk("reset_busy", int'(busy), 1);
      chk("reset_char_ready", int'(char_ready), 0);
      model_clear_all();
      check_cursor("reset_cursor");

      // power-up clear: exactly COLS*ROWS busy cycles
      reset = 1'b0;
      count_busy(n);
      chk("powerup_clear_cycles", n, COLS*ROWS);
      chk("powerup_ready", int'(char_ready), 1);
      check_cursor("powerup_cursor");
      sweep_all();
      read_tile(0, 80);
      read_tile(29, 127);
      read_tile(30, 0);
      read_tile(31, 5);
      drain();

      // "HI" back to back
      send_code(8'h48, 1'b1);
      send_code(8'h49, 1'b1);
      chk("hi_consecutive", last_acc - prev_acc, 1);
      check_cursor("hi_cursor");
      read_tile(0, 0);
      read_tile(0, 1);
      drain();

      // 80 x 'A' from (0,0): last one wraps and clears row 1
      send_code(8'h0D, 1'b1);
      for (int i = 0; i < COLS; i++) send_code(8'h41, 1'b1);
      check_cursor("row_wrap_cursor");
      sweep_row(0);
      sweep_row(1);

      // walk down to (29,5), then LF wraps to row 0
      while (mr != ROWS-1) send_code(8'h0A, 1'b1);
      for (int i = 0; i < 5; i++) send_code(8'($urandom_range(33, 126)), 1'b1);
      check_cursor("pre_lf_cursor");
      send_code(8'h0A, 1'b1);
      check_cursor("lf_wrap_cursor");
      sweep_row(0);
      sweep_row(29);

      // random mix of printable, control and ignored codes
      for (int i = 0; i < 250; i++) send_code(rand_code(), 1'b1);
      check_cursor("random_cursor");
      sweep_all();

      // FF homes cursor; then "AB" and three backspaces
      send_code(8'h0C, 1'b1);
      check_cursor("ff_cursor");
      send_code(8'h41, 1'b1);
      send_code(8'h42, 1'b1);
      send_code(8'h08, 1'b1);
      send_code(8'h08, 1'b1);
      send_code(8'h08, 1'b1);
      check_cursor("bs_cursor");
      read_tile(0, 0);
      read_tile(0, 1);
      read_tile(0, 2);
      drain();

      // reset part-way through a FF clear restarts the full clear
      send_code(8'h51, 1'b1);
      send_code(8'h0C, 1'b0);
      repeat (1000) @(negedge clk);
      chk("mid_clear_busy", int'(busy), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_clear_all();
      count_busy(n);
      chk("reset_restart_cycles", n, COLS*ROWS);
      check_cursor("reset_restart_cursor");

      // high code is consumed without effect
      send_code(8'h90, 1'b1);
      check_cursor("ignored_code_cursor");
      sweep_row(0);

      chk("exp_q_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // absolute time limit so the run always ends
   initial begin
      #5ms;
      $display("FAIL global_timeout: got cycle %0d expected end of stimulus", cyc);
      $fatal(1);
   end

endmodule

// File: doc/text_buffer_writer.md
Name: text_buffer_writer

Overview:
- Producer side of the character display path. Accepts a stream of ASCII codes and maintains a cursor over an 80x30 tile text buffer (8x16 glyphs on 640x480).
- Writes printable codes into an internal dual-port tile RAM. Handles CR/LF/BS/FF control codes and clears rows as the cursor enters them.
- The renderer reads the buffer per tile through the read port and feeds the returned code to the glyph ROM address.

Parameters:
- COLS, 80, tile columns
- ROWS, 30, tile rows
- BLANK, 8'h20, fill code used for clears
- ADDR_W, 12, tile RAM address width (must satisfy 2^ADDR_W >= COLS*ROWS)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- char_in  in  8  ASCII code to append
- char_valid  in  1  char_in valid
- char_ready  out  1  block can accept a code this cycle
- rd_col  in  7  renderer tile column (pixel x[9:3])
- rd_row  in  5  renderer tile row (pixel y[8:4])
- rd_ascii  out  8  code stored at (rd_row, rd_col), 1-cycle latency
- cursor_col  out  7  current cursor column
- cursor_row  out  5  current cursor row
- busy  out  1  clear in progress

Behaviour:
- Clock and reset: one clock domain (clk); reset is synchronous and active-high.
- Handshake:
  - A code is accepted on a rising edge with char_valid && char_ready.
  - char_ready = (state == IDLE).
  - busy = ~char_ready.
- Reset values:
  - cursor_col = 0, cursor_row = 0, rd_ascii = 0.
  - State enters CLR_ALL, so char_ready = 0 and busy = 1.
- Address rule:
  - addr = row*COLS + col, computed as {row,6'b0} + {row,4'b0} + col, ADDR_W bits, no multiplier.
  - Applies to both the write and read ports.
- Tile RAM:
  - COLS*ROWS x 8, one write port, one registered read port.
  - rd_ascii updates every cycle from the previous cycle's rd_row/rd_col; it is independent of state.
  - Read and write at the same address in the same cycle returns the old data.
  - Out-of-range read coordinates (col >= 80 or row >= 30) return BLANK.
- FSM states:
  - IDLE: waits for an accepted code.
  - CLR_ALL: writes BLANK to addresses 0..COLS*ROWS-1, one per cycle (2400 cycles). Then cursor = (0,0) and the FSM returns to IDLE.
  - CLR_ROW: writes BLANK to cols 0..COLS-1 of cursor_row, one per cycle (80 cycles), then returns to IDLE.
- Code handling in IDLE (the accepting edge does the write and cursor update):
  - 0x20..0x7E, printable:
    - Write char_in at the cursor.
    - If col < COLS-1: col += 1, stay IDLE.
    - Else: col = 0, row = (row == ROWS-1) ? 0 : row+1, go to CLR_ROW.
  - 0x0D, CR: col = 0, no write, stay IDLE.
  - 0x0A, LF: col = 0, row advances with the same wrap as above, go to CLR_ROW.
  - 0x08, BS:
    - If col > 0: col -= 1 and write BLANK at the new position.
    - If col == 0: no-op.
    - Stays IDLE in both cases.
  - 0x0C, FF: go to CLR_ALL (cursor homes at the end).
  - Any other code, including >= 0x80: accepted and discarded, no state change.
- No scrolling: wrap from row ROWS-1 returns to row 0, and CLR_ROW blanks it.
- Throughput: one printable code per cycle except at row crossings, which cost COLS stall cycles.
- Reset asserted in any state aborts the state, applies the reset values and restarts CLR_ALL. Partial clears are not preserved.
- A char_valid asserted while busy is held off; char_in must remain stable until accepted.

Decomposition:
- Shared package text_pkg holds:
  - COLS, ROWS, BLANK, ADDR_W.
  - Control-code constants CC_CR, CC_LF, CC_BS, CC_FF.
  - FSM state enum {IDLE, CLR_ALL, CLR_ROW}.
- One sub-module is natural: tile_ram (simple dual-port, sync write, registered read), inferable as BRAM.
- The address computation is a package function tile_addr(row, col).

Test Plan:
- Reset, hold char_valid = 0:
  - busy = 1 for exactly 2400 cycles, then char_ready = 1 with cursor (0,0).
  - Every rd_ascii sweep returns 0x20.
- Send "HI" (0x48, 0x49) back-to-back:
  - Accepted on consecutive cycles; cursor = (0,2).
  - Reading (0,0) gives 0x48 and (0,1) gives 0x49, one cycle after presenting the address.
- Send 80 x 0x41 (starts at (0,0)):
  - The 80th code wraps the cursor to (1,0) and char_ready drops for 80 cycles.
  - Row 0 reads all 0x41; row 1 reads all 0x20.
- Cursor at (29,5), send LF:
  - Cursor = (0,0), 80-cycle CLR_ROW; row 0 is blank afterwards and row 29 is unchanged.
- Send "AB", BS, BS, BS:
  - Cursor ends (0,0); tiles (0,0) and (0,1) read 0x20; the third BS is a no-op.
- During CLR_ALL triggered by FF, assert reset at cycle 1000:
  - CLR_ALL restarts; busy stays high for a further 2400 cycles from the reset cycle and the cursor is (0,0).
  - Send 0x90: accepted with no write and no cursor change.
